// File: rtl/mux4to1_rr_collector_if.sv
// Four-lane producer bundle plus the single merged output stream.
// Modport slave faces the collector; master faces the producers and the consumer.
interface mux4to1_rr_collector_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel
  );
endinterface

// File: rtl/mux4to1_rr_collector.sv
// Round-robin 4-to-1 collector with a single registered output stage.
// Each output word carries the index of the lane it came from.
module mux4to1_rr_collector #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux4to1_rr_collector_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic [1:0]       last_q;

  logic             can_load;
  logic             any_v;
  logic [1:0]       grant_d;
  logic [1:0]       idx;
  logic [WIDTH-1:0] data_d;

  assign can_load = (state_q == EMPTY) | bus.out_ready;

  // Search starts one past the last winner, so the last winner ranks lowest.
  always_comb begin
    grant_d = last_q;
    any_v   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + k[1:0];
      if (!any_v && bus.in_valid[idx]) begin
        grant_d = idx;
        any_v   = 1'b1;
      end
    end
  end

  assign data_d = bus.in_data[grant_d*WIDTH +: WIDTH];

  always_comb begin
    bus.in_ready = 4'b0000;
    if (any_v && can_load) begin
      bus.in_ready[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 2'b00;
      last_q  <= 2'd3;
    end else if (can_load) begin
      if (any_v) begin
        state_q <= FULL;
        data_q  <= data_d;
        sel_q   <= grant_d;
        last_q  <= grant_d;
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_mux4to1_rr_collector.sv
// Directed table-driven bench for the round-robin collector.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_mux4to1_rr_collector;

  localparam int W = 8;

  logic clk;
  logic rst;

  mux4to1_rr_collector_if #(.WIDTH(W)) bus ();

  mux4to1_rr_collector #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  iv;
    logic [31:0] d;
    logic        ordy;
    logic        chk;
    logic [3:0]  ird;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] DDEF = 32'h13121110;
  localparam logic [31:0] DA5  = 32'h13A51110;
  localparam logic [31:0] D3C  = 32'h13123C10;

  task automatic add(
    input logic r, input logic [3:0] iv, input logic [31:0] d,
    input logic ordy, input logic chk, input logic [3:0] ird,
    input logic ov, input logic [7:0] od, input logic [1:0] os);
    vec_t v;
    v.r = r; v.iv = iv; v.d = d; v.ordy = ordy; v.chk = chk;
    v.ird = ird; v.ov = ov; v.od = od; v.os = os;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] iv,
                       input logic [31:0] d, input logic ordy);
    rst          = r;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.out_ready = ordy;
  endtask

  task automatic check_out(input string tag, input logic ov,
                           input logic [7:0] od, input logic [1:0] os);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
    check({tag, " out_data"},  32'(bus.out_data),  32'(od));
    check({tag, " out_sel"},   32'(bus.out_sel),   32'(os));
  endtask

  initial begin
    // r  iv       data  ordy chk ird      ov   od     os
    add(1, 4'b1111, DDEF, 1, 0, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'b1111, DDEF, 1, 1, 4'b0001, 0, 8'h00, 2'd0);
    add(0, 4'b0000, DDEF, 1, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b0100, DA5,  1, 1, 4'b0100, 0, 8'h00, 2'd0);
    add(0, 4'b0000, DDEF, 1, 1, 4'b0000, 1, 8'hA5, 2'd2);
    add(0, 4'b0000, DDEF, 1, 1, 4'b0000, 0, 8'hA5, 2'd2);
    add(1, 4'b0000, DDEF, 1, 1, 4'b0000, 0, 8'hA5, 2'd2);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0001, 0, 8'h00, 2'd0);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0010, 1, 8'h10, 2'd0);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0100, 1, 8'h11, 2'd1);
    add(0, 4'b1111, DDEF, 1, 1, 4'b1000, 1, 8'h12, 2'd2);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0001, 1, 8'h13, 2'd3);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0010, 1, 8'h10, 2'd0);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0100, 1, 8'h11, 2'd1);
    add(0, 4'b1111, DDEF, 1, 1, 4'b1000, 1, 8'h12, 2'd2);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0001, 1, 8'h13, 2'd3);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0010, 1, 8'h10, 2'd0);
    add(0, 4'b1111, DDEF, 0, 1, 4'b0000, 1, 8'h11, 2'd1);
    add(0, 4'b1111, DDEF, 0, 1, 4'b0000, 1, 8'h11, 2'd1);
    add(0, 4'b1111, DDEF, 0, 1, 4'b0000, 1, 8'h11, 2'd1);
    add(0, 4'b1111, DDEF, 1, 1, 4'b0100, 1, 8'h11, 2'd1);
    add(0, 4'b0000, DDEF, 1, 1, 4'b0000, 1, 8'h12, 2'd2);
    add(0, 4'b1001, DDEF, 0, 1, 4'b1000, 0, 8'h12, 2'd2);
    add(0, 4'b1001, DDEF, 0, 1, 4'b0000, 1, 8'h13, 2'd3);
    add(0, 4'b0000, DDEF, 1, 1, 4'b0000, 1, 8'h13, 2'd3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d in_ready", i),
              32'(bus.in_ready), 32'(tbl[i].ird));
        check_out($sformatf("row%0d", i), tbl[i].ov, tbl[i].od, tbl[i].os);
      end
    end

    // Load 3C from lane 1, then reset while the consumer is draining it.
    @(negedge clk);
    drive(0, 4'b0010, D3C, 0);
    #1;
    check("mid_rst load in_ready", 32'(bus.in_ready), 32'h2);
    @(negedge clk);
    drive(1, 4'b1111, DDEF, 1);
    #1;
    check_out("mid_rst full", 1'b1, 8'h3C, 2'd1);
    @(negedge clk);
    drive(0, 4'b1111, DDEF, 1);
    #1;
    check_out("mid_rst after", 1'b0, 8'h00, 2'd0);
    check("mid_rst restart in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    drive(0, 4'b0000, DDEF, 1);
    #1;
    check_out("mid_rst first", 1'b1, 8'h10, 2'd0);

    // A lane that drops its request before winning simply loses it.
    @(negedge clk);
    drive(0, 4'b0000, DDEF, 1);
    #1;
    check("drop idle out_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    drive(0, 4'b0110, DDEF, 0);
    #1;
    check("drop grant1 in_ready", 32'(bus.in_ready), 32'h2);
    @(negedge clk);
    drive(0, 4'b1000, DDEF, 1);
    #1;
    check("drop grant3 in_ready", 32'(bus.in_ready), 32'h8);
    check_out("drop lane1 out", 1'b1, 8'h11, 2'd1);
    @(negedge clk);
    drive(0, 4'b0000, DDEF, 1);
    #1;
    check_out("drop lane3 out", 1'b1, 8'h13, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
